// File: rtl/skid_reg_pkg.sv
// Shared types and constants for the skid_reg two-entry pipeline stage.
package skid_reg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_e;

   localparam int STALL_CNT_W = 16;

   function automatic logic [1:0] state_occ(input state_e s);
      logic [1:0] occ;
      case (s)
         EMPTY:   occ = 2'd0;
         BUSY:    occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/skid_stall_cnt.sv
// Saturating event counter used to count upstream stall cycles.
module skid_stall_cnt
   import skid_reg_pkg::*;
#(
   parameter int W = STALL_CNT_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
   localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // next count: increment on enable, hold once saturated
   always_comb begin
      cnt_d = cnt_q;
      if (en && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_ONE;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= {W{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/skid_reg.sv
// Two-entry skid-buffer pipeline stage (main + skid register) with valid/ready handshake.
// Optional upstream stall counter port enabled by macro SKID_REG_STALL_CNT_EN.
module skid_reg
   import skid_reg_pkg::*;
#(
   parameter int WIDTH      = 18,
   parameter int SEL_EN_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   input  logic                   out_ready,
   output logic [1:0]             occupancy
`ifdef SKID_REG_STALL_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

   generate
      if (SEL_EN_REG != 0) begin : g_reg
         state_e           state_q;
         state_e           state_d;
         logic [WIDTH-1:0] main_q;
         logic [WIDTH-1:0] main_d;
         logic [WIDTH-1:0] skid_q;
         logic [WIDTH-1:0] skid_d;
         logic             in_ready_q;
         logic             in_ready_d;
         logic             out_valid_q;
         logic             out_valid_d;
         logic [1:0]       occ_q;
         logic [1:0]       occ_d;
         logic             accept_s;
         logic             fire_s;

         // next-state and datapath; handshake flags are derived from the next state
         // so in_ready/out_valid/occupancy come straight from flops
         always_comb begin
            accept_s = in_valid && in_ready_q;
            fire_s   = out_valid_q && out_ready;
            state_d  = state_q;
            main_d   = main_q;
            skid_d   = skid_q;
            case (state_q)
               EMPTY: begin
                  if (accept_s) begin
                     main_d  = in_data;
                     state_d = BUSY;
                  end else begin
                     state_d = EMPTY;
                  end
               end
               BUSY: begin
                  if (accept_s && fire_s) begin
                     main_d  = in_data;
                     state_d = BUSY;
                  end else if (accept_s) begin
                     skid_d  = in_data;
                     state_d = FULL;
                  end else if (fire_s) begin
                     state_d = EMPTY;
                  end else begin
                     state_d = BUSY;
                  end
               end
               FULL: begin
                  if (fire_s) begin
                     main_d  = skid_q;
                     state_d = BUSY;
                  end else begin
                     state_d = FULL;
                  end
               end
               default: begin
                  state_d = EMPTY;
               end
            endcase
            in_ready_d  = (state_d != FULL);
            out_valid_d = (state_d != EMPTY);
            occ_d       = state_occ(state_d);
         end

         // in_ready resets low and rises on the first clock after release
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               state_q     <= EMPTY;
               main_q      <= {WIDTH{1'b0}};
               skid_q      <= {WIDTH{1'b0}};
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               occ_q       <= 2'd0;
            end else begin
               state_q     <= state_d;
               main_q      <= main_d;
               skid_q      <= skid_d;
               in_ready_q  <= in_ready_d;
               out_valid_q <= out_valid_d;
               occ_q       <= occ_d;
            end
         end

         assign in_ready  = in_ready_q;
         assign out_valid = out_valid_q;
         assign out_data  = main_q;
         assign occupancy = occ_q;
      end else begin : g_bypass
         assign in_ready  = out_ready;
         assign out_valid = in_valid;
         assign out_data  = in_data;
         assign occupancy = 2'd0;
      end
   endgenerate

`ifdef SKID_REG_STALL_CNT_EN
   logic stall_en_s;

   assign stall_en_s = in_valid && !in_ready;

   skid_stall_cnt #(
      .W (STALL_CNT_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (stall_en_s),
      .cnt   (stall_cnt)
   );
`endif

endmodule

// File: tb/tb_skid_reg.sv
// Directed and randomized self-checking bench for skid_reg (buffered and bypass builds).
module tb_skid_reg;

   localparam int W = 18;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [W-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;
   logic [1:0]    occupancy;

   logic          b_in_valid;
   logic [W-1:0]  b_in_data;
   logic          b_in_ready;
   logic          b_out_valid;
   logic [W-1:0]  b_out_data;
   logic          b_out_ready;
   logic [1:0]    b_occupancy;

`ifdef SKID_REG_STALL_CNT_EN
   logic [15:0]   stall_cnt;
   logic [15:0]   b_stall_cnt;
`endif

   int checks_cnt = 0;
   int errors_cnt = 0;

   always #5 clk = ~clk;

   skid_reg #(.WIDTH(W), .SEL_EN_REG(1)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
`ifdef SKID_REG_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   skid_reg #(.WIDTH(W), .SEL_EN_REG(0)) u_byp (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_data   (b_in_data),
      .in_ready  (b_in_ready),
      .out_valid (b_out_valid),
      .out_data  (b_out_data),
      .out_ready (b_out_ready),
      .occupancy (b_occupancy)
`ifdef SKID_REG_STALL_CNT_EN
      ,
      .stall_cnt (b_stall_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [W-1:0] q[$];
   logic [W-1:0] data_next;
   logic [W-1:0] held;
   logic [W-1:0] exp_w;
   bit           stalled;

   initial begin
      rst_n       = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      out_ready   = 1'b0;
      b_in_valid  = 1'b0;
      b_in_data   = '0;
      b_out_ready = 1'b0;

      // reset state
      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_occ", occupancy, 0);
      check("rst_out_data", out_data, 0);
`ifdef SKID_REG_STALL_CNT_EN
      check("rst_stall_cnt", stall_cnt, 0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("rel_in_ready_low", in_ready, 0);
      tick();
      check("rel_in_ready_high", in_ready, 1);
      check("rel_out_valid", out_valid, 0);

      // single word, one-cycle latency
      in_valid = 1'b1; in_data = 18'h00001; out_ready = 1'b1;
      tick();
      check("lat_out_valid", out_valid, 1);
      check("lat_out_data", out_data, 18'h00001);
      check("lat_occ", occupancy, 1);
      in_valid = 1'b0;
      tick();
      check("lat_drain_valid", out_valid, 0);
      check("lat_drain_occ", occupancy, 0);

      // fill both entries with downstream stalled, then release
      out_ready = 1'b0; in_valid = 1'b1; in_data = 18'h0000A;
      tick();
      check("fill1_occ", occupancy, 1);
      check("fill1_in_ready", in_ready, 1);
      in_data = 18'h0000B;
      tick();
      check("fill2_occ", occupancy, 2);
      check("fill2_in_ready", in_ready, 0);
      check("fill2_out_data", out_data, 18'h0000A);
      in_data = 18'h0000C;
      tick();
      check("full_hold_data", out_data, 18'h0000A);
      check("full_hold_occ", occupancy, 2);
      in_valid = 1'b0; out_ready = 1'b1;
      check("full_first_data", out_data, 18'h0000A);
      tick();
      check("full_second_data", out_data, 18'h0000B);
      check("full_second_valid", out_valid, 1);
      check("full_second_occ", occupancy, 1);
      check("full_second_rdy", in_ready, 1);
      tick();
      check("full_empty_valid", out_valid, 0);

      // back-to-back streaming at one word per cycle
      in_valid = 1'b1; in_data = 18'h00C01;
      tick();
      check("stream_c", out_data, 18'h00C01);
      in_data = 18'h00D02;
      tick();
      check("stream_d", out_data, 18'h00D02);
      check("stream_d_occ", occupancy, 1);
      in_data = 18'h00E03;
      tick();
      check("stream_e", out_data, 18'h00E03);
      in_valid = 1'b0;
      tick();
      check("stream_end_valid", out_valid, 0);

      // reset in the middle of a cycle while FULL
      out_ready = 1'b0; in_valid = 1'b1; in_data = 18'h00111;
      tick();
      in_data = 18'h00222;
      tick();
      check("mid_full_occ", occupancy, 2);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_occ", occupancy, 0);
      check("mid_rst_rdy", in_ready, 0);
      check("mid_rst_data", out_data, 0);
      tick();
      rst_n = 1'b1;
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("mid_rel_no_stale", out_valid, 0);
         tick();
      end

      // randomized traffic against a queue scoreboard
      data_next = 18'h00100;
      stalled   = 1'b0;
      held      = '0;
      for (int i = 0; i < 10000; i++) begin
         check("rnd_occ", occupancy, q.size());
         check("rnd_in_ready", in_ready, q.size() != 2);
         check("rnd_out_valid", out_valid, q.size() != 0);
         if (stalled) check("rnd_hold", out_data, held);
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = data_next;
         if (out_valid && out_ready) begin
            if (q.size() > 0) begin
               exp_w = q.pop_front();
               check("rnd_data", out_data, exp_w);
            end else begin
               check("rnd_spurious", out_valid, 0);
            end
         end
         stalled = out_valid && !out_ready;
         held    = out_data;
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            data_next = data_next + 18'd1;
         end
         tick();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (out_valid) begin
            if (q.size() > 0) begin
               exp_w = q.pop_front();
               check("drain_data", out_data, exp_w);
            end else begin
               check("drain_spurious", out_valid, 0);
            end
         end
         tick();
      end
      check("drain_left", q.size(), 0);
      check("drain_valid", out_valid, 0);

      // combinational bypass build
      b_in_valid = 1'b1; b_in_data = 18'h3FFFF; b_out_ready = 1'b0;
      #1;
      check("byp_data", b_out_data, 18'h3FFFF);
      check("byp_valid", b_out_valid, 1);
      check("byp_rdy_low", b_in_ready, 0);
      check("byp_occ", b_occupancy, 0);
      b_out_ready = 1'b1;
      #1;
      check("byp_rdy_high", b_in_ready, 1);
      b_in_valid = 1'b0; b_in_data = 18'h12345;
      #1;
      check("byp_valid_low", b_out_valid, 0);
      check("byp_data2", b_out_data, 18'h12345);

`ifdef SKID_REG_STALL_CNT_EN
      // stall counter counts and saturates while FULL
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #1;
      check("sc_rst", stall_cnt, 0);
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1; in_data = 18'h00555;
      tick();
      tick();
      check("sc_full_occ", occupancy, 2);
      check("sc_zero", stall_cnt, 0);
      repeat (10) tick();
      check("sc_ten", stall_cnt, 16'd10);
      repeat (69990) tick();
      check("sc_sat", stall_cnt, 16'hFFFF);
      tick();
      check("sc_sat_hold", stall_cnt, 16'hFFFF);
      in_valid = 1'b0;
`endif

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
